// File: rtl/fir_filter_multichannel_tdm.sv
// Time-multiplexed multichannel FIR filter: one shared MAC and per-channel circular delay lines in one RAM.
// Optional macro FIR_TDM_SATURATE_EN: clamp the narrowed output instead of two's-complement wrap.
module fir_filter_multichannel_tdm #(
  parameter int DATA_WIDTH   = 24,
  parameter int COEF_WIDTH   = 18,
  parameter int FIR_DEPTH    = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int OUT_SHIFT    = 0,
  localparam int AW          = $clog2(FIR_DEPTH),
  localparam int CW          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int ACC_WIDTH   = DATA_WIDTH + COEF_WIDTH + $clog2(FIR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] iv_din,
  input  logic [CW-1:0]         iv_din_ch,
  input  logic                  i_din_valid,
  output logic                  o_din_ready,
  input  logic                  i_coef_we,
  input  logic [AW-1:0]         iv_coef_addr,
  input  logic [COEF_WIDTH-1:0] iv_coef_data,
  output logic                  o_coef_ready,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic [CW-1:0]         ov_dout_ch,
  output logic                  o_dout_valid,
  input  logic                  i_dout_ready
);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_MAC    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;
  localparam logic [2:0] S_OUTPUT = 3'd6;

  localparam int RW        = CW + AW;
  localparam int RAM_DEPTH = NUM_CHANNELS * FIR_DEPTH;
  localparam int PW        = DATA_WIDTH + COEF_WIDTH;
  localparam int RB        = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic signed [ACC_WIDTH:0] RND_BIAS =
    (OUT_SHIFT > 0) ? ({{ACC_WIDTH{1'b0}}, 1'b1} << RB) : {(ACC_WIDTH+1){1'b0}};
  localparam logic signed [ACC_WIDTH:0] MAX_OUT =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_OUT =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0]                   state;
  logic [2:0]                   next_state;
  logic [RW-1:0]                clr_cnt;
  logic [AW-1:0]                wr_ptr [0:(1<<CW)-1];
  logic [AW-1:0]                mac_cnt;
  logic                         drain_cnt;
  logic                         round_ph;
  logic [DATA_WIDTH-1:0]        smp;
  logic [CW-1:0]                smp_ch;

  logic [DATA_WIDTH-1:0]        dly_mem [0:(1<<RW)-1];
  logic [COEF_WIDTH-1:0]        coef_mem [0:FIR_DEPTH-1];
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic signed [COEF_WIDTH-1:0] coef_q;
  logic                         rd_vld;
  logic signed [PW-1:0]         prod;
  logic                         prod_vld;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH:0]    acc_ext;
  logic signed [ACC_WIDTH:0]    shifted;
  logic [DATA_WIDTH-1:0]        narrowed;

  logic                         din_accept;
  logic                         coef_wr;
  logic                         ch_in_range;
  logic                         last_clr;
  logic [AW-1:0]                cur_ptr;
  logic [AW-1:0]                new_ptr;
  logic [RW-1:0]                rd_addr;

  assign din_accept  = i_din_valid && o_din_ready;
  assign coef_wr     = i_coef_we && o_coef_ready;
  assign ch_in_range = (int'(iv_din_ch) < NUM_CHANNELS);
  assign last_clr    = (clr_cnt == RW'(RAM_DEPTH - 1));
  assign cur_ptr     = wr_ptr[smp_ch];
  assign new_ptr     = cur_ptr - AW'(1);
  assign rd_addr     = {smp_ch, cur_ptr + mac_cnt};
  assign acc_ext     = {acc[ACC_WIDTH-1], acc};

  // Next-state decode for the sequencing FSM
  always_comb begin
    next_state = state;
    case (state)
      S_CLEAR:  next_state = last_clr ? S_IDLE : S_CLEAR;
      S_IDLE: begin
        if (din_accept && ch_in_range) begin
          next_state = S_WRITE;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WRITE:  next_state = S_MAC;
      S_MAC:    next_state = (mac_cnt == AW'(FIR_DEPTH - 1)) ? S_DRAIN : S_MAC;
      S_DRAIN:  next_state = drain_cnt ? S_ROUND : S_DRAIN;
      S_ROUND:  next_state = round_ph ? S_OUTPUT : S_ROUND;
      S_OUTPUT: next_state = i_dout_ready ? S_IDLE : S_OUTPUT;
      default:  next_state = S_CLEAR;
    endcase
  end

  // Narrowing of the rounded, shifted accumulator to the output width
  always_comb begin
    narrowed = shifted[DATA_WIDTH-1:0];
`ifdef FIR_TDM_SATURATE_EN
    if (shifted > MAX_OUT) begin
      narrowed = MAX_OUT[DATA_WIDTH-1:0];
    end else if (shifted < MIN_OUT) begin
      narrowed = MIN_OUT[DATA_WIDTH-1:0];
    end else begin
      narrowed = shifted[DATA_WIDTH-1:0];
    end
`else
    narrowed = shifted[DATA_WIDTH-1:0];
`endif
  end

  // FSM state, counters, pointers and registered handshake/output signals
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_CLEAR;
      clr_cnt      <= '0;
      mac_cnt      <= '0;
      drain_cnt    <= 1'b0;
      round_ph     <= 1'b0;
      smp          <= '0;
      smp_ch       <= '0;
      shifted      <= '0;
      ov_dout      <= '0;
      ov_dout_ch   <= '0;
      o_dout_valid <= 1'b0;
      o_din_ready  <= 1'b0;
      o_coef_ready <= 1'b0;
      for (int i = 0; i < (1 << CW); i++) begin
        wr_ptr[i] <= '0;
      end
    end else begin
      state        <= next_state;
      o_din_ready  <= (next_state == S_IDLE);
      o_coef_ready <= (next_state == S_IDLE) || (next_state == S_CLEAR);
      case (state)
        S_CLEAR: clr_cnt <= last_clr ? '0 : clr_cnt + RW'(1);
        S_IDLE: begin
          if (din_accept) begin
            smp    <= iv_din;
            smp_ch <= iv_din_ch;
          end
        end
        S_WRITE: begin
          wr_ptr[smp_ch] <= new_ptr;
          mac_cnt        <= '0;
        end
        S_MAC:   mac_cnt <= mac_cnt + AW'(1);
        S_DRAIN: drain_cnt <= ~drain_cnt;
        S_ROUND: begin
          round_ph <= ~round_ph;
          // Phase 0 rounds and shifts; phase 1 narrows into the output register
          if (!round_ph) begin
            shifted <= (acc_ext + RND_BIAS) >>> OUT_SHIFT;
          end else begin
            ov_dout      <= narrowed;
            ov_dout_ch   <= smp_ch;
            o_dout_valid <= 1'b1;
          end
        end
        S_OUTPUT: begin
          if (i_dout_ready) begin
            o_dout_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // MAC pipeline: read-valid, registered product, full-precision accumulate
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_vld   <= 1'b0;
      prod_vld <= 1'b0;
      prod     <= '0;
      acc      <= '0;
    end else begin
      rd_vld   <= (state == S_MAC);
      prod_vld <= rd_vld;
      prod     <= rd_data * coef_q;
      if (state == S_WRITE) begin
        acc <= '0;
      end else if (prod_vld) begin
        acc <= acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
      end
    end
  end

  // Delay-line RAM: clear sweep, newest-sample write, one-cycle read
  always_ff @(posedge i_clk) begin
    if (state == S_CLEAR) begin
      dly_mem[clr_cnt] <= '0;
    end else if (state == S_WRITE) begin
      dly_mem[{smp_ch, new_ptr}] <= smp;
    end
    rd_data <= dly_mem[rd_addr];
  end

  // Coefficient RAM survives reset; read alongside the delay line
  always_ff @(posedge i_clk) begin
    if (coef_wr) begin
      coef_mem[iv_coef_addr] <= iv_coef_data;
    end
    coef_q <= coef_mem[mac_cnt];
  end

endmodule

// File: tb/tb_fir_filter_multichannel_tdm.sv
// Scoreboard bench for fir_filter_multichannel_tdm: two instances (OUT_SHIFT 0 and 2) share one stimulus.
module tb_fir_filter_multichannel_tdm;
  localparam int DW = 16;
  localparam int CWD = 16;
  localparam int FD = 4;
  localparam int NC = 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] iv_din;
  logic [0:0]    iv_din_ch;
  logic          i_din_valid;
  logic          i_coef_we;
  logic [1:0]    iv_coef_addr;
  logic [CWD-1:0] iv_coef_data;
  logic          i_dout_ready;
  logic          o_din_ready, o_coef_ready, o_dout_valid;
  logic [DW-1:0] ov_dout;
  logic [0:0]    ov_dout_ch;
  logic          r_din_ready, r_coef_ready, r_dout_valid;
  logic [DW-1:0] r_dout;
  logic [0:0]    r_dout_ch;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int          ch;
    logic [15:0] y0;
    logic [15:0] y2;
  } exp_t;
  exp_t   sb[$];
  longint coef_m[FD];
  longint hist[NC][FD];

  always #5 i_clk = ~i_clk;

  fir_filter_multichannel_tdm #(.DATA_WIDTH(DW), .COEF_WIDTH(CWD), .FIR_DEPTH(FD),
    .NUM_CHANNELS(NC), .OUT_SHIFT(0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .iv_din(iv_din), .iv_din_ch(iv_din_ch),
    .i_din_valid(i_din_valid), .o_din_ready(o_din_ready), .i_coef_we(i_coef_we),
    .iv_coef_addr(iv_coef_addr), .iv_coef_data(iv_coef_data), .o_coef_ready(o_coef_ready),
    .ov_dout(ov_dout), .ov_dout_ch(ov_dout_ch), .o_dout_valid(o_dout_valid),
    .i_dout_ready(i_dout_ready));

  fir_filter_multichannel_tdm #(.DATA_WIDTH(DW), .COEF_WIDTH(CWD), .FIR_DEPTH(FD),
    .NUM_CHANNELS(NC), .OUT_SHIFT(2)) dut_rnd (
    .i_clk(i_clk), .i_rst(i_rst), .iv_din(iv_din), .iv_din_ch(iv_din_ch),
    .i_din_valid(i_din_valid), .o_din_ready(r_din_ready), .i_coef_we(i_coef_we),
    .iv_coef_addr(iv_coef_addr), .iv_coef_data(iv_coef_data), .o_coef_ready(r_coef_ready),
    .ov_dout(r_dout), .ov_dout_ch(r_dout_ch), .o_dout_valid(r_dout_valid),
    .i_dout_ready(i_dout_ready));

  function automatic logic [15:0] narrow(input longint v);
`ifdef FIR_TDM_SATURATE_EN
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_push(input int ch, input int x);
    exp_t   e;
    longint acc;
    for (int k = FD - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = x;
    acc = 0;
    for (int k = 0; k < FD; k++) acc += coef_m[k] * hist[ch][k];
    e.ch = ch;
    e.y0 = narrow(acc);
    e.y2 = narrow((acc + 2) >>> 2);
    sb.push_back(e);
  endtask

  task automatic clear_model;
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < FD; k++) hist[c][k] = 0;
  endtask

  task automatic wait_din_ready;
    int n = 0;
    while (!o_din_ready && n < 200) begin
      tick();
      n++;
    end
    compared++;
    if (o_din_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL din_ready_timeout: o_din_ready=%b required 1", o_din_ready);
    end
  endtask

  task automatic write_coef(input int k, input int v);
    int n = 0;
    while (!o_coef_ready && n < 200) begin
      tick();
      n++;
    end
    compared++;
    if (o_coef_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL coef_ready_timeout: o_coef_ready=%b required 1", o_coef_ready);
    end
    i_coef_we = 1'b1;
    iv_coef_addr = 2'(k);
    iv_coef_data = 16'(v);
    tick();
    i_coef_we = 1'b0;
    coef_m[k] = v;
  endtask

  // Waits for the result of an accepted sample, checks latency and scoreboard entry, lets it transfer.
  task automatic get_result;
    exp_t e;
    int   lat = 0;
    while (!o_dout_valid && lat < 100) begin
      tick();
      lat++;
    end
    compared++;
    if (lat != FD + 5) begin
      mismatched++;
      $display("FAIL latency: got %0d edges required %0d", lat, FD + 5);
    end
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL scoreboard_empty: got output %0d required no output", $signed(ov_dout));
    end else begin
      e = sb.pop_front();
      if (ov_dout !== e.y0) begin
        mismatched++;
        $display("FAIL dout: got %0d required %0d", $signed(ov_dout), $signed(e.y0));
      end
      compared++;
      if (ov_dout_ch !== 1'(e.ch)) begin
        mismatched++;
        $display("FAIL dout_ch: got %0d required %0d", ov_dout_ch, e.ch);
      end
      compared++;
      if (r_dout !== e.y2) begin
        mismatched++;
        $display("FAIL dout_rounded: got %0d required %0d", $signed(r_dout), $signed(e.y2));
      end
    end
    tick();
    compared++;
    if (o_dout_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL valid_drop: o_dout_valid=%b required 0", o_dout_valid);
    end
  endtask

  task automatic send_sample(input int ch, input int x);
    wait_din_ready();
    iv_din = 16'(x);
    iv_din_ch = 1'(ch);
    i_din_valid = 1'b1;
    tick();
    i_din_valid = 1'b0;
    model_push(ch, x);
    get_result();
  endtask

  task automatic count_clear;
    int n = 1;
    tick();
    compared++;
    if (o_coef_ready !== 1'b1 || o_din_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_ready: coef_ready=%b din_ready=%b required 1 0", o_coef_ready, o_din_ready);
    end
    while (!o_din_ready && n < 100) begin
      tick();
      n++;
    end
    compared++;
    if (n != NC * FD) begin
      mismatched++;
      $display("FAIL clear_cycles: got %0d required %0d", n, NC * FD);
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    i_din_valid = 1'b0;
    iv_din = '0;
    iv_din_ch = '0;
    i_coef_we = 1'b0;
    iv_coef_addr = '0;
    iv_coef_data = '0;
    i_dout_ready = 1'b1;
    clear_model();
    #3;
    compared++;
    if ({o_din_ready, o_coef_ready, o_dout_valid, ov_dout, ov_dout_ch} !== '0) begin
      mismatched++;
      $display("FAIL reset_values: din_rdy=%b coef_rdy=%b valid=%b dout=%0d ch=%0d required all 0",
               o_din_ready, o_coef_ready, o_dout_valid, ov_dout, ov_dout_ch);
    end
    tick();
    tick();
    i_rst = 1'b0;
    count_clear();
  endtask

  task automatic test_impulse;
    for (int k = 0; k < FD; k++) write_coef(k, k + 1);
    send_sample(0, 1);
    for (int i = 0; i < 4; i++) send_sample(0, 0);
  endtask

  task automatic test_isolation;
    for (int i = 0; i < 5; i++) begin
      send_sample(1, 10);
      send_sample(0, (i == 0) ? 1 : 0);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] cap;
    logic [0:0]  cap_ch;
    exp_t        e;
    int          n = 0;
    i_dout_ready = 1'b0;
    wait_din_ready();
    iv_din = 16'd5;
    iv_din_ch = 1'b1;
    i_din_valid = 1'b1;
    tick();
    i_din_valid = 1'b0;
    model_push(1, 5);
    while (!o_dout_valid && n < 100) begin
      tick();
      n++;
    end
    cap = ov_dout;
    cap_ch = ov_dout_ch;
    e = sb.pop_front();
    compared++;
    if (cap !== e.y0 || cap_ch !== 1'(e.ch)) begin
      mismatched++;
      $display("FAIL bp_value: got %0d ch %0d required %0d ch %0d", $signed(cap), cap_ch, $signed(e.y0), e.ch);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      compared++;
      if (ov_dout !== cap || ov_dout_ch !== cap_ch || o_dout_valid !== 1'b1 || o_din_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold: cycle %0d dout=%0d ch=%0d valid=%b din_rdy=%b required %0d %0d 1 0",
                 i, $signed(ov_dout), ov_dout_ch, o_dout_valid, o_din_ready, $signed(cap), cap_ch);
      end
    end
    i_dout_ready = 1'b1;
    tick();
    compared++;
    if (o_dout_valid !== 1'b0 || o_din_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_release: valid=%b din_rdy=%b required 0 1", o_dout_valid, o_din_ready);
    end
    tick();
    compared++;
    if (o_dout_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_single: valid=%b required 0", o_dout_valid);
    end
  endtask

  task automatic test_overflow;
    for (int k = 0; k < FD; k++) write_coef(k, 16384);
    for (int i = 0; i < 4; i++) send_sample(0, 32767);
  endtask

  task automatic test_rounding;
    write_coef(0, 1);
    for (int k = 1; k < FD; k++) write_coef(k, 0);
    send_sample(0, 6);
    send_sample(0, -6);
  endtask

  task automatic test_coef_same_cycle;
    wait_din_ready();
    i_coef_we = 1'b1;
    iv_coef_addr = 2'd1;
    iv_coef_data = 16'd3;
    iv_din = 16'd2;
    iv_din_ch = 1'b1;
    i_din_valid = 1'b1;
    tick();
    i_coef_we = 1'b0;
    i_din_valid = 1'b0;
    coef_m[1] = 3;
    model_push(1, 2);
    get_result();
  endtask

  task automatic test_reset_mid_mac;
    for (int k = 0; k < FD; k++) write_coef(k, k + 1);
    wait_din_ready();
    iv_din = 16'd7;
    iv_din_ch = 1'b1;
    i_din_valid = 1'b1;
    tick();
    i_din_valid = 1'b0;
    tick();
    tick();
    tick();
    i_rst = 1'b1;
    #1;
    compared++;
    if (o_dout_valid !== 1'b0 || o_din_ready !== 1'b0 || o_coef_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_mac: valid=%b din_rdy=%b coef_rdy=%b required 0 0 0",
               o_dout_valid, o_din_ready, o_coef_ready);
    end
    tick();
    i_rst = 1'b0;
    clear_model();
    count_clear();
    compared++;
    if (o_dout_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL discarded_result: valid=%b required 0", o_dout_valid);
    end
    send_sample(1, 3);
    send_sample(0, 1);
    for (int i = 0; i < 3; i++) send_sample(0, 0);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_isolation();
    test_backpressure();
    test_overflow();
    test_rounding();
    test_coef_same_cycle();
    test_reset_mid_mac();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
